// File: rtl/pulse_seq_pkg.sv
// Shared types and widths for the pulse sequencer: run state, mode codes,
// the packed configuration word and a saturating marker adder.
package pulse_seq_pkg;

   localparam int CNT_W = 32;
   localparam int T_W   = 16;
   localparam int N_W   = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [N_W-1:0] MODE_CW   = N_W'(0);
   localparam logic [N_W-1:0] MODE_HAHN = N_W'(1);

   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [T_W-1:0]   p1wid;
      logic [T_W-1:0]   p2wid;
      logic [T_W-1:0]   delay;
      logic [T_W-1:0]   nut_w;
      logic [T_W-1:0]   nut_d;
      logic [T_W-1:0]   bl_start;
      logic [T_W-1:0]   bl_stop;
      logic [N_W-1:0]   cpmg;
      logic             block;
   } cfg_t;

   // Markers saturate at all-ones so an overflowing event simply lands past the period end.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/pulse_seq_markers.sv
// Incremental pi-pulse and blocking-window marker generator. Markers step by
// 2*delay+p2 each time a pulse or window finishes; outputs are combinational on the counter.
module pulse_seq_markers
   import pulse_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic [T_W-1:0]   i_p1wid,
   input  logic [T_W-1:0]   i_p2wid,
   input  logic [T_W-1:0]   i_delay,
   input  logic [T_W-1:0]   i_bl_start,
   input  logic [T_W-1:0]   i_bl_stop,
   input  logic [N_W-1:0]   i_cpmg,
   output logic             o_pi,
   output logic             o_win,
   output logic             o_sync,
   output logic [N_W-1:0]   o_idx
);

   logic [CNT_W-1:0] r_s, r_e, r_wb;
   logic [N_W-1:0]   r_k, r_wk, r_idx;
   logic             r_pdone, r_wdone;

   logic [CNT_W-1:0] w_s, w_e, w_wb, w_step, w_s0, w_e0, w_win_lo, w_win_hi;
   logic [N_W-1:0]   w_k, w_wk, w_idx;
   logic             w_pdone, w_wdone, w_padv, w_wadv, w_none;
   logic [CNT_W:0]   w_cnt_p1;

   assign w_none   = (i_cpmg < MODE_HAHN);
   assign w_step   = sat_add(sat_add(CNT_W'(i_delay), CNT_W'(i_delay)), CNT_W'(i_p2wid));
   assign w_s0     = sat_add(CNT_W'(i_p1wid), CNT_W'(i_delay));
   assign w_e0     = sat_add(w_s0, CNT_W'(i_p2wid));
   assign w_cnt_p1 = {1'b0, i_cnt} + {{CNT_W{1'b0}}, 1'b1};

   // At c=0 the first-pulse markers are derived directly from the (just loaded) configuration.
   always_comb begin
      w_k     = r_k;
      w_s     = r_s;
      w_e     = r_e;
      w_pdone = r_pdone;
      w_wk    = r_wk;
      w_wb    = r_wb;
      w_wdone = r_wdone;
      w_idx   = r_idx;
      if (i_start) begin
         w_k     = N_W'(1);
         w_s     = w_s0;
         w_e     = w_e0;
         w_pdone = w_none;
         w_wk    = N_W'(1);
         w_wb    = w_e0;
         w_wdone = w_none;
         w_idx   = '0;
      end
   end

   assign w_win_lo = sat_add(w_wb, CNT_W'(i_bl_start));
   assign w_win_hi = sat_add(w_wb, CNT_W'(i_bl_stop));

   assign o_pi   = !w_pdone && (i_cnt >= w_s) && (i_cnt < w_e);
   assign o_idx  = (!w_pdone && (i_cnt == w_s)) ? w_k : w_idx;
   assign o_sync = !w_pdone && !((w_k == i_cpmg) && (i_cnt >= w_e));
   assign o_win  = !w_wdone && (i_bl_stop > i_bl_start) &&
                   (i_cnt >= w_win_lo) && (i_cnt < w_win_hi);

   // Advance on the last cycle of the pulse/window (or at its start when it is empty).
   assign w_padv = !w_pdone && (i_cnt >= w_s) && (w_cnt_p1 >= {1'b0, w_e});
   assign w_wadv = !w_wdone && (w_cnt_p1 >= {1'b0, w_win_hi});

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s     <= '0;
         r_e     <= '0;
         r_wb    <= '0;
         r_k     <= '0;
         r_wk    <= '0;
         r_idx   <= '0;
         r_pdone <= 1'b1;
         r_wdone <= 1'b1;
      end else if (i_en) begin
         r_idx   <= o_idx;
         r_k     <= w_padv ? w_k + N_W'(1) : w_k;
         r_s     <= w_padv ? sat_add(w_s, w_step) : w_s;
         r_e     <= w_padv ? sat_add(w_e, w_step) : w_e;
         r_pdone <= w_padv ? (w_k >= i_cpmg) : w_pdone;
         r_wk    <= w_wadv ? w_wk + N_W'(1) : w_wk;
         r_wb    <= w_wadv ? sat_add(w_wb, w_step) : w_wb;
         r_wdone <= w_wadv ? (w_wk >= i_cpmg) : w_wdone;
      end
   end

endmodule

// File: rtl/pulse_sequencer.sv
// Run-controlled CW / Hahn / CPMG pulse sequencer with a double-buffered
// configuration that is only applied at a period boundary.
//
//   state | meaning
//   IDLE  | outputs quiet, pending config applied at once, waits for run
//   RUN   | counter sweeps 0..period-1; leaves at period end if run is low
module pulse_sequencer
   import pulse_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cfg_valid,
   output logic             o_cfg_ready,
   input  logic [CNT_W-1:0] i_cfg_period,
   input  logic [T_W-1:0]   i_cfg_p1wid,
   input  logic [T_W-1:0]   i_cfg_p2wid,
   input  logic [T_W-1:0]   i_cfg_delay,
   input  logic [T_W-1:0]   i_cfg_nut_w,
   input  logic [T_W-1:0]   i_cfg_nut_d,
   input  logic [N_W-1:0]   i_cfg_cpmg,
   input  logic [T_W-1:0]   i_cfg_bl_start,
   input  logic [T_W-1:0]   i_cfg_bl_stop,
   input  logic             i_cfg_block,
   input  logic             i_run,
   output logic             o_sync_on,
   output logic             o_pulse_on,
   output logic             o_inhib,
   output logic [N_W-1:0]   o_pulse_idx,
   output logic             o_period_strobe
);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   cfg_t             r_act, r_pend, w_cfg_in;
   logic             r_pend_full;
   logic             r_sync, r_pulse, r_inhib, r_strobe;
   logic [N_W-1:0]   r_idx;

   logic [CNT_W-1:0] w_period, w_nut_end, w_nut_st;
   logic             w_wrap, w_accept, w_load, w_nut;
   logic             w_m_pi, w_m_win, w_m_sync;
   logic [N_W-1:0]   w_m_idx;
   logic             w_sync, w_pulse, w_inhib, w_strobe;
   logic [N_W-1:0]   w_idx;

   assign w_cfg_in = '{period:   i_cfg_period,
                       p1wid:    i_cfg_p1wid,
                       p2wid:    i_cfg_p2wid,
                       delay:    i_cfg_delay,
                       nut_w:    i_cfg_nut_w,
                       nut_d:    i_cfg_nut_d,
                       bl_start: i_cfg_bl_start,
                       bl_stop:  i_cfg_bl_stop,
                       cpmg:     i_cfg_cpmg,
                       block:    i_cfg_block};

   assign w_period = (r_act.period < CNT_W'(2)) ? CNT_W'(2) : r_act.period;
   assign w_wrap   = (r_state == RUN) && (r_cnt == w_period - CNT_W'(1));
   assign w_accept = i_cfg_valid && !r_pend_full;
   assign w_load   = r_pend_full && ((r_state == IDLE) || w_wrap);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_run) w_state_nxt = RUN;
         RUN:     if (w_wrap && !i_run) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                         r_cnt <= '0;
      else if ((r_state == RUN) && !w_wrap) r_cnt <= r_cnt + CNT_W'(1);
      else                                  r_cnt <= '0;
   end

   // A handshake in the same cycle as a copy refills the slot the copy just drained.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_act       <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
      end else begin
         if (w_load) r_act <= r_pend;
         if (w_accept) begin
            r_pend      <= w_cfg_in;
            r_pend_full <= 1'b1;
         end else if (w_load) begin
            r_pend_full <= 1'b0;
         end
      end
   end

   pulse_seq_markers u_markers (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (r_state == RUN),
      .i_start    ((r_state == RUN) && (r_cnt == '0)),
      .i_cnt      (r_cnt),
      .i_p1wid    (r_act.p1wid),
      .i_p2wid    (r_act.p2wid),
      .i_delay    (r_act.delay),
      .i_bl_start (r_act.bl_start),
      .i_bl_stop  (r_act.bl_stop),
      .i_cpmg     (r_act.cpmg),
      .o_pi       (w_m_pi),
      .o_win      (w_m_win),
      .o_sync     (w_m_sync),
      .o_idx      (w_m_idx)
   );

   // Nutation window clamps at 0 instead of wrapping when nut_d+nut_w exceeds the period.
   assign w_nut_end = (CNT_W'(r_act.nut_d) >= w_period) ? '0 : w_period - CNT_W'(r_act.nut_d);
   assign w_nut_st  = (CNT_W'(r_act.nut_w) >= w_nut_end) ? '0 : w_nut_end - CNT_W'(r_act.nut_w);
   assign w_nut     = (r_act.nut_w != '0) && (r_cnt >= w_nut_st) && (r_cnt < w_nut_end);

   always_comb begin
      w_sync   = 1'b0;
      w_pulse  = 1'b0;
      w_inhib  = r_act.block;
      w_idx    = '0;
      w_strobe = 1'b0;
      if (r_state == RUN) begin
         w_strobe = (r_cnt == '0);
         if (r_act.cpmg == MODE_CW) begin
            w_pulse = 1'b1;
            w_inhib = 1'b0;
            w_sync  = (r_cnt < (w_period >> 1));
         end else begin
            w_pulse = (r_cnt < CNT_W'(r_act.p1wid)) || w_m_pi || w_nut;
            w_inhib = r_act.block && !w_m_win;
            w_sync  = w_m_sync;
            w_idx   = w_m_idx;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync   <= 1'b0;
         r_pulse  <= 1'b0;
         r_inhib  <= 1'b0;
         r_idx    <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_sync   <= w_sync;
         r_pulse  <= w_pulse;
         r_inhib  <= w_inhib;
         r_idx    <= w_idx;
         r_strobe <= w_strobe;
      end
   end

   assign o_sync_on       = r_sync;
   assign o_pulse_on      = r_pulse;
   assign o_inhib         = r_inhib;
   assign o_pulse_idx     = r_idx;
   assign o_period_strobe = r_strobe;
   assign o_cfg_ready     = !r_pend_full;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: per-period waveform capture compared
// against hand-derived pulse/window intervals, plus handshake, run and reset scenarios.
module tb_pulse_sequencer;
   import pulse_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        valid = 1'b0;
   logic        ready;
   logic [31:0] period = '0;
   logic [15:0] p1 = '0, p2 = '0, dly = '0, nw = '0, nd = '0, bls = '0, blp = '0;
   logic [7:0]  cpmg = '0;
   logic        blk = 1'b0;
   logic        run = 1'b0;
   logic        sync, pulse, inhib, strobe;
   logic [7:0]  idx;

   int checks = 0;
   int failures = 0;

   logic       cp [0:3999];
   logic       ci [0:3999];
   logic       cs [0:3999];
   logic       ct [0:3999];
   logic [7:0] cx [0:3999];

   pulse_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(valid), .o_cfg_ready(ready),
      .i_cfg_period(period), .i_cfg_p1wid(p1), .i_cfg_p2wid(p2), .i_cfg_delay(dly),
      .i_cfg_nut_w(nw), .i_cfg_nut_d(nd), .i_cfg_cpmg(cpmg),
      .i_cfg_bl_start(bls), .i_cfg_bl_stop(blp), .i_cfg_block(blk), .i_run(run),
      .o_sync_on(sync), .o_pulse_on(pulse), .o_inhib(inhib), .o_pulse_idx(idx),
      .o_period_strobe(strobe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      run = 1'b0;
      valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_cfg(input int per, input int a, input int b, input int d, input int nwv,
                          input int ndv, input int s0, input int s1, input int n, input bit bk);
      period = 32'(per); p1 = 16'(a); p2 = 16'(b); dly = 16'(d);
      nw = 16'(nwv); nd = 16'(ndv); bls = 16'(s0); blp = 16'(s1);
      cpmg = 8'(n); blk = bk;
   endtask

   task automatic offer(output bit to);
      int n = 0;
      to = 1'b0;
      valid = 1'b1;
      while (!ready && n < 10000) begin tick(); n++; end
      if (!ready) to = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   task automatic wait_strobe(output bit to, output int n);
      n = 0;
      to = 1'b0;
      do begin tick(); n++; end while (!strobe && n < 10000);
      if (!strobe) to = 1'b1;
   endtask

   task automatic capture(input int len);
      for (int i = 0; i < len; i++) begin
         if (i > 0) tick();
         cp[i] = pulse; ci[i] = inhib; cs[i] = sync; ct[i] = strobe; cx[i] = idx;
      end
   endtask

   task automatic test_reset();
      valid = 1'b0; run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sync, pulse, inhib, strobe, idx} !== 12'h0) begin
         failures++;
         $display("FAIL reset_outputs: got sync=%b pulse=%b inhib=%b strobe=%b idx=%0d expected all 0",
                  sync, pulse, inhib, strobe, idx);
      end
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if ({sync, pulse, inhib, strobe, idx, ready} !== 13'h1) begin
         failures++;
         $display("FAIL idle_outputs: got sync=%b pulse=%b inhib=%b strobe=%b idx=%0d ready=%b",
                  sync, pulse, inhib, strobe, idx, ready);
      end
   endtask

   task automatic test_cpmg();
      bit to; int n;
      int bp = 0, bi = 0, bs = 0, bt = 0, bx = 0, fp = 0, fi = 0, fs = 0, fx = 0;
      logic ep, ei, es; logic [7:0] ex;
      reset_dut();
      set_cfg(4000, 30, 60, 200, 0, 0, 50, 100, 3, 1'b1);
      offer(to);
      checks++;
      if (to || ready !== 1'b0) begin failures++; $display("FAIL cpmg_accept: ready=%b timeout=%b expected 0/0", ready, to); end
      tick();
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL cpmg_ready_return: got %b expected 1", ready); end
      run = 1'b1;
      wait_strobe(to, n);
      checks++;
      if (to) begin failures++; $display("FAIL cpmg_start: no period_strobe within 10000 cycles"); end
      capture(4000);
      for (int c = 0; c < 4000; c++) begin
         ep = (c < 30) || (c >= 230 && c < 290) || (c >= 690 && c < 750) || (c >= 1150 && c < 1210);
         ei = !((c >= 340 && c < 390) || (c >= 800 && c < 850) || (c >= 1260 && c < 1310));
         es = (c < 1210);
         ex = (c >= 1150) ? 8'd3 : (c >= 690) ? 8'd2 : (c >= 230) ? 8'd1 : 8'd0;
         if (cp[c] !== ep) begin if (bp == 0) fp = c; bp++; end
         if (ci[c] !== ei) begin if (bi == 0) fi = c; bi++; end
         if (cs[c] !== es) begin if (bs == 0) fs = c; bs++; end
         if (cx[c] !== ex) begin if (bx == 0) fx = c; bx++; end
         if (ct[c] !== (c == 0)) bt++;
      end
      checks++;
      if (bp != 0) begin failures++; $display("FAIL cpmg_pulse_on: %0d cycles wrong, first c=%0d got %b", bp, fp, cp[fp]); end
      checks++;
      if (bi != 0) begin failures++; $display("FAIL cpmg_inhib: %0d cycles wrong, first c=%0d got %b", bi, fi, ci[fi]); end
      checks++;
      if (bs != 0) begin failures++; $display("FAIL cpmg_sync_on: %0d cycles wrong, first c=%0d got %b", bs, fs, cs[fs]); end
      checks++;
      if (bx != 0) begin failures++; $display("FAIL cpmg_pulse_idx: %0d cycles wrong, first c=%0d got %0d", bx, fx, cx[fx]); end
      checks++;
      if (bt != 0) begin failures++; $display("FAIL cpmg_strobe: %0d cycles wrong, expected high only at c=0", bt); end
   endtask

   task automatic test_cw();
      bit to; int n;
      int bp = 0, bi = 0, bs = 0, fs = 0;
      reset_dut();
      set_cfg(1000, 30, 60, 200, 0, 0, 50, 100, 0, 1'b1);
      offer(to);
      tick();
      run = 1'b1;
      wait_strobe(to, n);
      checks++;
      if (to) begin failures++; $display("FAIL cw_start: no period_strobe within 10000 cycles"); end
      capture(1000);
      for (int c = 0; c < 1000; c++) begin
         if (cp[c] !== 1'b1) bp++;
         if (ci[c] !== 1'b0) bi++;
         if (cs[c] !== (c < 500)) begin if (bs == 0) fs = c; bs++; end
      end
      checks++;
      if (bp != 0) begin failures++; $display("FAIL cw_pulse_on: %0d cycles low, expected constant 1", bp); end
      checks++;
      if (bi != 0) begin failures++; $display("FAIL cw_inhib: %0d cycles high, expected constant 0", bi); end
      checks++;
      if (bs != 0) begin failures++; $display("FAIL cw_sync_on: %0d cycles wrong, first c=%0d got %b", bs, fs, cs[fs]); end
      tick();
      checks++;
      if (strobe !== 1'b1) begin failures++; $display("FAIL cw_period: strobe at c=1000 got %b expected 1", strobe); end
   endtask

   task automatic test_nutation();
      bit to; int n;
      int bp = 0, bi = 0, bs = 0, bx = 0, fp = 0;
      logic ep;
      reset_dut();
      set_cfg(4000, 30, 60, 200, 20, 100, 50, 100, 1, 1'b1);
      offer(to);
      tick();
      run = 1'b1;
      wait_strobe(to, n);
      checks++;
      if (to) begin failures++; $display("FAIL nut_start: no period_strobe within 10000 cycles"); end
      capture(4000);
      for (int c = 0; c < 4000; c++) begin
         ep = (c < 30) || (c >= 230 && c < 290) || (c >= 3880 && c < 3900);
         if (cp[c] !== ep) begin if (bp == 0) fp = c; bp++; end
         if (ci[c] !== !(c >= 340 && c < 390)) bi++;
         if (cs[c] !== (c < 290)) bs++;
         if (cx[c] !== ((c >= 230) ? 8'd1 : 8'd0)) bx++;
      end
      checks++;
      if (bp != 0) begin failures++; $display("FAIL nut_pulse_on: %0d cycles wrong, first c=%0d got %b", bp, fp, cp[fp]); end
      checks++;
      if (bi + bs + bx != 0) begin
         failures++;
         $display("FAIL hahn_inhib_sync_idx: wrong cycles inhib=%0d sync=%0d idx=%0d expected 0", bi, bs, bx);
      end
   endtask

   task automatic test_back_to_back();
      bit to; int n; int nrdy;
      reset_dut();
      set_cfg(4000, 30, 60, 200, 0, 0, 50, 100, 3, 1'b1);
      offer(to);
      tick();
      run = 1'b1;
      wait_strobe(to, n);
      repeat (1500) tick();
      set_cfg(2000, 30, 60, 200, 0, 0, 50, 100, 3, 1'b1);
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_before: got %b expected 1", ready); end
      valid = 1'b1;
      tick();
      set_cfg(3000, 30, 60, 200, 0, 0, 50, 100, 3, 1'b1);
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after: got %b expected 0", ready); end
      n = 0; nrdy = 0;
      do begin tick(); n++; if (!strobe && ready) nrdy++; end while (!strobe && n < 10000);
      checks++;
      if (n != 2499) begin failures++; $display("FAIL b2b_old_period: %0d cycles to wrap expected 2499", n); end
      checks++;
      if (nrdy != 1 || ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stall: ready high %0d cycles before wrap (expected 1), ready at wrap %b expected 0", nrdy, ready);
      end
      valid = 1'b0;
      wait_strobe(to, n);
      checks++;
      if (n != 2000) begin failures++; $display("FAIL b2b_new_period: spacing %0d expected 2000", n); end
      wait_strobe(to, n);
      checks++;
      if (n != 3000) begin failures++; $display("FAIL b2b_stalled_cfg: spacing %0d expected 3000", n); end
   endtask

   task automatic test_run_drop();
      bit to; int n; int bad;
      reset_dut();
      set_cfg(4000, 30, 60, 200, 0, 0, 50, 100, 3, 1'b1);
      offer(to);
      tick();
      run = 1'b1;
      wait_strobe(to, n);
      repeat (100) tick();
      run = 1'b0;
      repeat (130) tick();
      checks++;
      if (pulse !== 1'b1 || idx !== 8'd1) begin
         failures++;
         $display("FAIL drop_no_truncate: at c=230 pulse=%b idx=%0d expected 1/1", pulse, idx);
      end
      repeat (3769) tick();
      checks++;
      if (strobe !== 1'b0 || inhib !== 1'b1) begin
         failures++;
         $display("FAIL drop_last_cycle: at c=3999 strobe=%b inhib=%b expected 0/1", strobe, inhib);
      end
      bad = 0;
      for (int i = 0; i < 4100; i++) begin
         tick();
         if (strobe !== 1'b0 || pulse !== 1'b0 || sync !== 1'b0 || inhib !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL drop_idle: %0d cycles not idle (expected 0)", bad); end
   endtask

   task automatic test_reset_mid();
      bit to; int n;
      reset_dut();
      set_cfg(4000, 30, 60, 200, 0, 0, 50, 100, 3, 1'b1);
      offer(to);
      tick();
      run = 1'b1;
      wait_strobe(to, n);
      repeat (700) tick();
      checks++;
      if (pulse !== 1'b1 || idx !== 8'd2 || sync !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: at c=700 pulse=%b idx=%0d sync=%b expected 1/2/1", pulse, idx, sync);
      end
      set_cfg(3000, 30, 60, 200, 0, 0, 50, 100, 0, 1'b1);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL mid_pending: ready %b expected 0", ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sync, pulse, inhib, strobe, idx, ready} !== 13'h1) begin
         failures++;
         $display("FAIL mid_async_reset: sync=%b pulse=%b inhib=%b strobe=%b idx=%0d ready=%b",
                  sync, pulse, inhib, strobe, idx, ready);
      end
      run = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      run = 1'b1;
      wait_strobe(to, n);
      wait_strobe(to, n);
      checks++;
      if (n != 2 || pulse !== 1'b1) begin
         failures++;
         $display("FAIL mid_pending_lost: period %0d pulse=%b expected 2/1", n, pulse);
      end
      run = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cpmg();
      test_cw();
      test_nutation();
      test_back_to_back();
      test_run_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Parametrised, run-controlled successor to the fixed-program pulse generator. It produces switch-pulse, blocking-switch and scope-trigger waveforms for CW, Hahn-echo and N-pulse CPMG sequences, plus an optional nutation pulse. Configuration is double-buffered: a new configuration is accepted through a valid/ready handshake and applied only at a period boundary, so a sequence is never torn mid-period. The block sits between the host-register interface and the RF switch/attenuator pins, in the PLL clock domain.

## Interface
- CNT_W, 32: period counter and marker width, in cycles.
- T_W, 16: width of pulse, delay and window fields.
- N_W, 8: width of the CPMG pulse count and of the pulse index.
- clk  in  1  PLL clock; the only clock.
- reset  in  1  asynchronous, active-low.
- cfg_valid  in  1  a configuration word is offered.
- cfg_ready  out  1  the pending slot is empty.
- cfg_period  in  CNT_W  period length in cycles; values below 2 are clamped to 2.
- cfg_p1wid, cfg_p2wid, cfg_delay  in  T_W  first-pulse width, pi-pulse width, half inter-pulse delay.
- cfg_nut_w, cfg_nut_d  in  T_W  nutation pulse width, and its end offset before the period end.
- cfg_cpmg  in  N_W  0 = CW, 1 = Hahn, N>1 = CPMG with N pi pulses.
- cfg_bl_start, cfg_bl_stop  in  T_W  block-open window, measured from the end of each pi pulse.
- cfg_block  in  1  blocking enabled.
- run  in  1  level; sequences repeat while it is high.
- sync_on, pulse_on, inhib  out  1  scope trigger, switch pulse, blocking switch.
- pulse_idx  out  N_W  index of the most recently started pulse (0 = first pulse).
- period_strobe  out  1  one-cycle pulse on the first cycle of every period.

## Operation
- States: IDLE, RUN.
  - IDLE goes to RUN when run=1; the counter c starts at 0.
  - RUN goes to IDLE at the end of a period (c = period−1) if run=0 at that cycle.
  - Deasserting run never truncates a period.
- Counter: c counts 0 … period−1, then wraps to 0.
- Configuration handling:
  - A handshake completes when cfg_valid=1 and cfg_ready=1. The accepted word is latched into the pending slot and cfg_ready drops.
  - The pending word is copied to the active registers on the cycle c wraps to 0, or immediately in IDLE. cfg_ready then returns to 1 on the following cycle.
  - If a handshake and a boundary copy fall in the same cycle, the previously pending word is applied and the new word becomes pending.
- CW mode (cpmg=0): pulse_on=1, inhib=0, sync_on=1 for c < period/2 (floor).
- Pulsed mode (cpmg=N≥1):
  - First pulse: high for [0, p1).
  - Pi pulse k=1..N: starts at s_k = p1+delay+(k−1)(2·delay+p2) and ends at e_k = s_k+p2. Markers are generated incrementally by adders; no multipliers.
  - Block window after pulse k: inhib=0 on [e_k+bl_start, e_k+bl_stop); otherwise inhib=cfg_block.
  - bl_stop ≤ bl_start means no window.
  - sync_on=1 for c < e_N.
  - pulse_idx is 0 at c=0 and becomes k at s_k.
- Nutation pulse: high on [period−nut_d−nut_w, period−nut_d) and ORed into pulse_on. nut_w=0 disables it.
- Arithmetic: all markers are computed at CNT_W bits and never wrap. Any event whose marker is ≥ period does not occur in that period.
- IDLE and reset values: sync_on=0, pulse_on=0, inhib=cfg_block (0 after reset), pulse_idx=0, period_strobe=0, cfg_ready=1, active configuration = all zeros.

## Timing
- All outputs are registered. The output at cycle t+1 reflects c at cycle t, so latency is 1 from the counter.
- period_strobe is high in the cycle the outputs reflect c=0.
- An edge stated as "at c=X" appears on the output one cycle after the counter holds X.
- Reset asserted mid-sequence forces every output to its reset value immediately (asynchronously). The pending slot is discarded. After release, the block is in IDLE.
- A configuration accepted during period P takes effect at the first cycle of period P+1. An offer made while cfg_ready=0 stalls until the boundary.

## Structure
- Package pulse_seq_pkg holds:
  - the state enum (IDLE, RUN);
  - the mode constants MODE_CW=0 and MODE_HAHN=1;
  - a packed cfg_t struct carrying all cfg_* fields.
- Sub-module pulse_seq_markers holds the incremental s_k/e_k/window marker generator and its pulse counter. The top level keeps the FSM, the counter, the pending/active registers and the output registers.

## Test plan
- period=4000, p1=30, p2=60, delay=200, cpmg=3, bl_start=50, bl_stop=100, block=1 -> pulse_on high on c∈[0,30), [230,290), [690,750), [1150,1210); inhib low on [340,390), [800,850), [1260,1310); sync_on falls at c=1210; pulse_idx = 1, 2, 3 at c = 230, 690, 1150.
- Same configuration but cpmg=0, period=1000 -> pulse_on constantly 1, inhib 0, sync_on high for c<500.
- cpmg=1, nut_w=20, nut_d=100, period=4000 -> a second pulse_on interval at c∈[3880,3900); no pulse after e_1=290 other than the nutation pulse.
- New configuration with period 2000 offered at c=1500 of a 4000-cycle period -> cfg_ready=0 until the wrap; the old period completes; the next period_strobe-to-period_strobe spacing is 2000.
- run dropped at c=100 -> the period completes to 3999, then the block enters IDLE with outputs sync_on=0, pulse_on=0, inhib=1.
- reset asserted at c=700 -> all outputs reach their reset values without waiting for a clock edge; the pending configuration is lost; cfg_ready=1 after release.
